// File: rtl/uart_rx_frame_check_if.sv
// Frame checker bit-stream and result interface.
// master drives the sampler side; slave is the checker.
interface uart_rx_frame_check_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  Frame_start;
   logic                  Bit_valid;
   logic                  Sampled_bit;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  STOP2;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_valid;
   logic                  Start_glitch;
   logic                  Par_err;
   logic                  Stp_err;
   logic                  Busy;

   modport master (
      output Frame_start, Bit_valid, Sampled_bit,
      output PAR_EN, PAR_TYP, STOP2,
      input  P_DATA, Data_valid, Start_glitch,
      input  Par_err, Stp_err, Busy
   );

   modport slave (
      input  Frame_start, Bit_valid, Sampled_bit,
      input  PAR_EN, PAR_TYP, STOP2,
      output P_DATA, Data_valid, Start_glitch,
      output Par_err, Stp_err, Busy
   );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: start/data/parity/stop validation.
// Optional saturating error counters: define UART_RX_ERR_CNT_EN.
module uart_rx_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
`ifdef UART_RX_ERR_CNT_EN
   output logic [CNT_WIDTH-1:0] Glitch_cnt,
   output logic [CNT_WIDTH-1:0] Par_err_cnt,
   output logic [CNT_WIDTH-1:0] Stp_err_cnt,
`endif
   uart_rx_frame_check_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

   state_t                state, state_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n, pdata_n;
   logic [BW-1:0]         bit_cnt, bit_cnt_n;
   logic                  par_flag, par_flag_n;
   logic                  stp_flag, stp_flag_n;
   logic                  stop_cnt, stop_cnt_n;
   logic                  cfg_pen, cfg_pen_n;
   logic                  cfg_ptyp, cfg_ptyp_n;
   logic                  cfg_s2, cfg_s2_n;
   logic                  dv_n, gl_n, pe_n, se_n;
   logic                  stp_bad;

   // Next-state, datapath and result pulse decode
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      bit_cnt_n  = bit_cnt;
      par_flag_n = par_flag;
      stp_flag_n = stp_flag;
      stop_cnt_n = stop_cnt;
      cfg_pen_n  = cfg_pen;
      cfg_ptyp_n = cfg_ptyp;
      cfg_s2_n   = cfg_s2;
      pdata_n    = bus.P_DATA;
      dv_n       = 1'b0;
      gl_n       = 1'b0;
      pe_n       = 1'b0;
      se_n       = 1'b0;
      stp_bad    = stp_flag | ~bus.Sampled_bit;
      if (bus.Frame_start) begin
         state_n    = START;
         cfg_pen_n  = bus.PAR_EN;
         cfg_ptyp_n = bus.PAR_TYP;
         cfg_s2_n   = bus.STOP2;
         par_flag_n = 1'b0;
         stp_flag_n = 1'b0;
         stop_cnt_n = 1'b0;
         bit_cnt_n  = '0;
      end else if (bus.Bit_valid) begin
         unique case (state)
            IDLE: ;
            START: begin
               if (bus.Sampled_bit) begin
                  gl_n    = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               shreg_n[bit_cnt] = bus.Sampled_bit;
               bit_cnt_n        = bit_cnt + 1'b1;
               if (bit_cnt == LAST)
                  state_n = cfg_pen ? PARITY : STOP;
            end
            PARITY: begin
               if (bus.Sampled_bit != (^shreg ^ cfg_ptyp))
                  par_flag_n = 1'b1;
               state_n = STOP;
            end
            STOP: begin
               stp_flag_n = stp_bad;
               if (!cfg_s2 || stop_cnt) begin
                  pe_n    = par_flag;
                  se_n    = stp_bad;
                  dv_n    = ~par_flag & ~stp_bad;
                  state_n = IDLE;
                  if (dv_n)
                     pdata_n = shreg;
               end else begin
                  stop_cnt_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state            <= IDLE;
         shreg            <= '0;
         bit_cnt          <= '0;
         par_flag         <= 1'b0;
         stp_flag         <= 1'b0;
         stop_cnt         <= 1'b0;
         cfg_pen          <= 1'b0;
         cfg_ptyp         <= 1'b0;
         cfg_s2           <= 1'b0;
         bus.P_DATA       <= '0;
         bus.Data_valid   <= 1'b0;
         bus.Start_glitch <= 1'b0;
         bus.Par_err      <= 1'b0;
         bus.Stp_err      <= 1'b0;
         bus.Busy         <= 1'b0;
      end else begin
         state            <= state_n;
         shreg            <= shreg_n;
         bit_cnt          <= bit_cnt_n;
         par_flag         <= par_flag_n;
         stp_flag         <= stp_flag_n;
         stop_cnt         <= stop_cnt_n;
         cfg_pen          <= cfg_pen_n;
         cfg_ptyp         <= cfg_ptyp_n;
         cfg_s2           <= cfg_s2_n;
         bus.P_DATA       <= pdata_n;
         bus.Data_valid   <= dv_n;
         bus.Start_glitch <= gl_n;
         bus.Par_err      <= pe_n;
         bus.Stp_err      <= se_n;
         bus.Busy         <= (state_n != IDLE);
      end
   end

`ifdef UART_RX_ERR_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CMAX = '1;

   // Saturating error counters, bumped with their pulse
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Glitch_cnt  <= '0;
         Par_err_cnt <= '0;
         Stp_err_cnt <= '0;
      end else begin
         if (gl_n && Glitch_cnt != CMAX)
            Glitch_cnt <= Glitch_cnt + 1'b1;
         if (pe_n && Par_err_cnt != CMAX)
            Par_err_cnt <= Par_err_cnt + 1'b1;
         if (se_n && Stp_err_cnt != CMAX)
            Stp_err_cnt <= Stp_err_cnt + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench for uart_rx_frame_check.
// Honours UART_RX_ERR_CNT_EN for the counter checks.
module tb_uart_rx_frame_check;
   localparam logic [3:0] K_DV = 4'b1000;
   localparam logic [3:0] K_GL = 4'b0100;
   localparam logic [3:0] K_PE = 4'b0010;
   localparam logic [3:0] K_SE = 4'b0001;

   typedef struct {
      logic [3:0] kind;
      logic [7:0] data;
      logic [1:0] gc;
      logic [1:0] pc;
      logic [1:0] sc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q[$];
   logic [1:0] m_gc = 0, m_pc = 0, m_sc = 0;

`ifdef UART_RX_ERR_CNT_EN
   logic [1:0] Glitch_cnt, Par_err_cnt, Stp_err_cnt;
`endif

   uart_rx_frame_check_if #(.DATA_WIDTH(8)) bus ();

   uart_rx_frame_check #(
      .DATA_WIDTH(8),
      .CNT_WIDTH (2)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
`ifdef UART_RX_ERR_CNT_EN
      .Glitch_cnt (Glitch_cnt),
      .Par_err_cnt(Par_err_cnt),
      .Stp_err_cnt(Stp_err_cnt),
`endif
      .bus        (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [1:0] sat(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   task automatic push(input logic [3:0] kind, input logic [7:0] d);
      exp_t e;
      if (kind & K_GL) m_gc = sat(m_gc);
      if (kind & K_PE) m_pc = sat(m_pc);
      if (kind & K_SE) m_sc = sat(m_sc);
      e.kind = kind;
      e.data = d;
      e.gc   = m_gc;
      e.pc   = m_pc;
      e.sc   = m_sc;
      q.push_back(e);
   endtask

   // Monitor: every result pulse must match the next expectation
   always @(negedge CLK) begin
      logic [3:0] act;
      exp_t e;
      act = {bus.Data_valid, bus.Start_glitch, bus.Par_err, bus.Stp_err};
      if (RST && act != 4'b0) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", {28'd0, act}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", {28'd0, act}, {28'd0, e.kind});
            chk("p_data", {24'd0, bus.P_DATA}, {24'd0, e.data});
`ifdef UART_RX_ERR_CNT_EN
            chk("glitch_cnt", {30'd0, Glitch_cnt}, {30'd0, e.gc});
            chk("par_err_cnt", {30'd0, Par_err_cnt}, {30'd0, e.pc});
            chk("stp_err_cnt", {30'd0, Stp_err_cnt}, {30'd0, e.sc});
`endif
         end
      end
   end

   task automatic fs(input bit pen, input bit ptyp, input bit s2);
      @(negedge CLK);
      bus.Frame_start = 1'b1;
      bus.PAR_EN      = pen;
      bus.PAR_TYP     = ptyp;
      bus.STOP2       = s2;
      @(negedge CLK);
      bus.Frame_start = 1'b0;
      bus.PAR_EN      = ~pen;
      bus.PAR_TYP     = ~ptyp;
      bus.STOP2       = ~s2;
   endtask

   task automatic bitv(input bit b);
      @(negedge CLK);
      bus.Bit_valid   = 1'b1;
      bus.Sampled_bit = b;
      @(negedge CLK);
      bus.Bit_valid   = 1'b0;
   endtask

   task automatic data8(input logic [7:0] d);
      for (int i = 0; i < 8; i++) bitv(d[i]);
   endtask

   task automatic frame(input logic [7:0] d, input bit pen,
                        input bit ptyp, input bit s2, input bit pb,
                        input bit sb0, input bit sb1);
      fs(pen, ptyp, s2);
      bitv(1'b0);
      data8(d);
      if (pen) bitv(pb);
      bitv(sb0);
      if (s2) bitv(sb1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.Frame_start = 1'b0;
      bus.Bit_valid   = 1'b0;
      bus.Sampled_bit = 1'b1;
      bus.PAR_EN      = 1'b0;
      bus.PAR_TYP     = 1'b0;
      bus.STOP2       = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_p_data", {24'd0, bus.P_DATA}, 32'd0);
      chk("rst_pulses", {28'd0, bus.Data_valid, bus.Start_glitch,
                         bus.Par_err, bus.Stp_err}, 32'd0);
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
      chk("rst_cnts", {26'd0, Glitch_cnt, Par_err_cnt, Stp_err_cnt}, 32'd0);
`endif
      RST = 1'b1;

      bitv(1'b0);
      push(K_DV, 8'hA5);
      frame(8'hA5, 0, 0, 0, 0, 1, 1);
      chk("busy_end_8n1", {31'd0, bus.Busy}, 32'd0);

      push(K_GL, 8'hA5);
      fs(0, 0, 0);
      chk("busy_start", {31'd0, bus.Busy}, 32'd1);
      bitv(1'b1);
      chk("busy_glitch", {31'd0, bus.Busy}, 32'd0);

      push(K_PE, 8'hA5);
      frame(8'h03, 1, 0, 0, 1, 1, 1);
      push(K_DV, 8'h03);
      frame(8'h03, 1, 0, 0, 0, 1, 1);
      push(K_DV, 8'h07);
      frame(8'h07, 1, 1, 0, 0, 1, 1);

      push(K_SE, 8'h07);
      frame(8'h5A, 0, 0, 1, 0, 1, 0);
      push(K_DV, 8'h5A);
      frame(8'h5A, 0, 0, 1, 0, 1, 1);
      chk("busy_end_2stop", {31'd0, bus.Busy}, 32'd0);

      push(K_PE | K_SE, 8'h5A);
      frame(8'h5A, 1, 0, 0, 1, 0, 0);

      fs(0, 0, 0);
      bitv(1'b0);
      for (int i = 0; i < 4; i++) bitv(1'b1);
      @(negedge CLK);
      bus.Frame_start = 1'b1;
      bus.Bit_valid   = 1'b1;
      bus.Sampled_bit = 1'b1;
      bus.PAR_EN      = 1'b0;
      bus.STOP2       = 1'b0;
      @(negedge CLK);
      bus.Frame_start = 1'b0;
      bus.Bit_valid   = 1'b0;
      chk("busy_abort", {31'd0, bus.Busy}, 32'd1);
      push(K_DV, 8'h3C);
      bitv(1'b0);
      data8(8'h3C);
      bitv(1'b1);

      fs(0, 0, 0);
      bitv(1'b0);
      bitv(1'b1);
      @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("busy_async_rst", {31'd0, bus.Busy}, 32'd0);
      chk("p_data_async_rst", {24'd0, bus.P_DATA}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
      chk("cnts_async_rst", {26'd0, Glitch_cnt, Par_err_cnt, Stp_err_cnt},
          32'd0);
`endif
      m_gc = 0;
      m_pc = 0;
      m_sc = 0;
      @(negedge CLK);
      RST = 1'b1;

      for (int i = 0; i < 5; i++) begin
         push(K_PE, 8'h00);
         frame(8'h03, 1, 0, 0, 1, 1, 1);
      end

      repeat (4) @(negedge CLK);
      chk("queue_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
- Parametrised frame checker for the UART receiver; supersedes the single-bit start glitch check.
- Consumes one oversampled bit per Bit_valid strobe from the data sampler, driven by the RX FSM.
- Validates the start bit, deserialises data LSB first, checks optional even/odd parity and 1 or 2 stop bits.
- Reports one-cycle result pulses to the RX controller and register file.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
CNT_WIDTH, 8, width of saturating error counters (ERR_CNT_EN only)

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-low
Frame_start  input  1  pulse: falling edge detected, begin new frame
Bit_valid  input  1  pulse: Sampled_bit holds the next frame bit
Sampled_bit  input  1  majority-voted bit value
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  0 = one stop bit, 1 = two stop bits
P_DATA  output  DATA_WIDTH  last good frame data
Data_valid  output  1  one-cycle pulse: good frame, P_DATA updated
Start_glitch  output  1  one-cycle pulse: start bit sampled high
Par_err  output  1  one-cycle pulse: parity mismatch
Stp_err  output  1  one-cycle pulse: stop bit sampled low
Busy  output  1  high while frame in progress
Glitch_cnt, Par_err_cnt, Stp_err_cnt  output  CNT_WIDTH each  error counters (ERR_CNT_EN only)

Behaviour:
- Reset: all outputs 0, P_DATA = 0, FSM in IDLE, internal flags cleared.
- All outputs registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: Bit_valid ignored. Frame_start -> START, Busy = 1.
- Configuration: PAR_EN, PAR_TYP and STOP2 are captured on Frame_start and held for the frame. Changes mid-frame have no effect.
- START: on Bit_valid:
  - bit = 1 -> Start_glitch = 1 next cycle, -> IDLE.
  - bit = 0 -> DATA.
- DATA:
  - Each Bit_valid shifts Sampled_bit into the shift register at index bit_cnt (LSB first).
  - After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
- PARITY: on Bit_valid, expected = XOR(data) ^ PAR_TYP; a mismatch sets internal par_flag. -> STOP.
- STOP:
  - Each Bit_valid with bit = 0 sets internal stp_flag.
  - Frame ends after 1 stop bit, or 2 if STOP2.
- Frame end, in the cycle after the final stop bit's Bit_valid:
  - Par_err = par_flag and Stp_err = stp_flag, each pulsed for one cycle.
  - If neither flag is set: Data_valid pulses and P_DATA is loaded in the same cycle.
  - Otherwise P_DATA is unchanged.
  - Busy drops, -> IDLE.
- Stp_err and Par_err may pulse together.
- Frame_start while Busy:
  - Aborts the current frame with no error or valid pulse.
  - Flags are cleared and the FSM restarts in START.
  - Frame_start takes priority over a coincident Bit_valid, which is ignored.
- Bit_valid is accepted at most once per cycle. Cycles without Bit_valid hold all state.
- Latency: each result pulse appears exactly 1 CLK after the deciding Bit_valid.
- Async reset mid-frame returns to IDLE immediately with no pulses.

Optional Feature:
- Macro UART_RX_ERR_CNT_EN.
- Defined:
  - Glitch_cnt, Par_err_cnt and Stp_err_cnt each increment in the same cycle as the corresponding pulse.
  - Each saturates at 2^CNT_WIDTH-1 (no wrap).
  - Each resets to 0 only on RST.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

Test Plan:
- 8N1, bits 0, 0xA5 LSB first, 1 -> Data_valid pulse, P_DATA = 0xA5, no error pulses.
- Frame_start then first Bit_valid = 1 -> Start_glitch pulse 1 cycle later, Busy = 0, P_DATA unchanged, Glitch_cnt +1 (ERR_CNT_EN).
- PAR_EN = 1, PAR_TYP = 0, data 0x03, parity bit 1, stop 1 -> Par_err pulse, no Data_valid, P_DATA keeps previous value. Same frame with parity 0 -> Data_valid, P_DATA = 0x03.
- STOP2 = 1, data 0x5A, stop bits 1, 0 -> Stp_err pulse after the second stop bit. Stop bits 1, 1 -> Data_valid.
- Frame_start asserted with Bit_valid during DATA bit 4 -> no pulses, FSM in START, next frame 0x3C received correctly.
- ERR_CNT_EN, CNT_WIDTH = 2: 5 parity-error frames -> Par_err_cnt reads 1, 2, 3, 3, 3.
